pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming servo-style PWM signal and reports its high time, its period and a decoded position code. It is the receive-side counterpart of the servo PWM generator. It sits between an external PWM pin (servo feedback or a loopback of the generator output) and the RAT I/O port space. The position code uses the same one-hot encoding as the generator's command input (4 = left, 2 = neutral, 1 = right), so software reads back what it commanded.

## Interface
Parameters:
- CNT_W, 21, counter/result width in CLK cycles
- TIMEOUT, 21'h1FFFFF, cycles without a qualifying edge before the signal is declared lost
- L_MAX, 21'h1ADB0, widths at or below this (110000 cycles) decode as left
- R_MIN, 21'h2DC6C, widths at or above this (187500 cycles) decode as right

Ports:
- CLK  in  1  system clock; the only clock
- RST  in  1  asynchronous, active-high reset
- pwm_in  in  1  asynchronous PWM input pin
- width  out  CNT_W  high time of the last complete period, in CLK cycles
- period  out  CNT_W  rising-to-rising time of the last complete period, in CLK cycles
- valid  out  1  one-cycle strobe; width/period/pos updated this cycle
- pos  out  3  decoded position: 3'b100 left, 3'b010 neutral, 3'b001 right, 3'b000 lost/none
- lost  out  1  high while no valid PWM is present

## Operation
- pwm_in passes through a 2-flop synchronizer and then an edge register. A rise or fall is a single-cycle pulse derived from the synchronized value and its delayed copy.
- FSM states: WAIT_LOW, WAIT_RISE, HIGH, LOW. Reset state is WAIT_LOW, so a partial first pulse is never measured.
- WAIT_LOW -> WAIT_RISE when the synchronized input is 0.
- WAIT_RISE -> HIGH on rise; hi_cnt <= 1, per_cnt <= 1.
- HIGH: both counters increment; on fall latch hi_cnt into hold_w and go to LOW.
- LOW: per_cnt increments. On rise:
  - width <= hold_w, period <= per_cnt, pos updated, valid <= 1, lost <= 0.
  - Counters restart at 1; state -> HIGH.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Timeout:
  - HIGH with per_cnt == TIMEOUT (stuck high / 100 % duty): lost <= 1, pos <= 0, state -> WAIT_LOW.
  - LOW or WAIT_RISE with per_cnt == TIMEOUT (stuck low / 0 % duty): lost <= 1, pos <= 0, state -> WAIT_RISE.
  - In WAIT_RISE, per_cnt counts from entry into the state.
- Decode: width <= L_MAX -> 100; width >= R_MIN -> 001; otherwise 010. Decode is evaluated on the new width in the same cycle it is latched.
- width and period hold their last values through a loss. Only pos and lost change.

## Timing
- Reset values: width = 0, period = 0, valid = 0, pos = 3'b000, lost = 1.
- RST asserted mid-measurement clears everything immediately (asynchronous). After release, the first valid requires a low, a full high, a low and the next rise.
- Latency: if pwm_in is first sampled high at CLK edge k, the rise pulse occurs in cycle k+2. valid, width, period and pos change at edge k+3.
- Measured width and period equal the pin's high time and period in CLK cycles exactly (±1 for asynchronous sampling). The synchronizer delay cancels because it is applied to both edges.
- valid is high for exactly one cycle per complete period. It is never asserted on a timeout.
- If a fall and a timeout occur in the same cycle in HIGH, the timeout wins.
- If a rise and a timeout occur in the same cycle in LOW, the rise wins: the period is reported and lost stays 0.

## Structure
- Package pwm_pkg:
  - state enum (WAIT_LOW, WAIT_RISE, HIGH, LOW)
  - position code constants POS_L = 3'b100, POS_N = 3'b010, POS_R = 3'b001, POS_NONE = 3'b000
  - servo timing constants shared with the generator: NEUTRAL = 150000, LEFT60 = 90000, RIGHT60 = 210000, FRAME = 21'h1FFFFE cycles
- Sub-module sync_edge: 2-flop synchronizer plus edge detector, with outputs level, rise and fall. Reused by other RAT input peripherals.

## Test plan
- Reset held, pwm_in toggling -> width = 0, period = 0, pos = 000, lost = 1, valid never high.
- Frame of 2097150 cycles, high 150000 cycles, 3 frames -> first valid at the start of the second frame; width = 150000, period = 2097150, pos = 010, lost = 0.
- High 90000 cycles, then 210000 cycles on the next frame -> consecutive valids report pos = 100 then 001. Widths are exact to ±1.
- After a good frame, pwm_in held low beyond TIMEOUT -> lost = 1 and pos = 000 at per_cnt = TIMEOUT; width stays 150000 and there is no valid. A subsequent good frame clears lost.
- pwm_in held high from reset past TIMEOUT -> lost stays 1, no valid. After release, the first full frame reports correctly.
- RST pulsed mid-high-phase -> outputs return to reset values asynchronously. The truncated pulse is not reported, and the next complete frame is.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the servo PWM generator and capture blocks.
// Position codes are one-hot so a readback matches the commanded value directly.
package pwm_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  localparam logic [2:0] POS_L    = 3'b100;
  localparam logic [2:0] POS_N    = 3'b010;
  localparam logic [2:0] POS_R    = 3'b001;
  localparam logic [2:0] POS_NONE = 3'b000;

  localparam logic [20:0] NEUTRAL = 21'd150000;
  localparam logic [20:0] LEFT60  = 21'd90000;
  localparam logic [20:0] RIGHT60 = 21'd210000;
  localparam logic [20:0] FRAME   = 21'h1FFFFE;

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchronizer plus registered rise/fall pulses; level is aligned with the pulses.
// Pin change sampled at edge k shows up as a one-cycle pulse after edge k+2; no backpressure.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Chain resets to RST_VAL so a pin already at that level produces no edge after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign level = s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM pin and decodes a one-hot servo position.
// Results and valid strobe update 3 cycles after the closing rise is sampled; no backpressure.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int               CNT_W   = 21,
  parameter logic [CNT_W-1:0] TIMEOUT = 21'h1FFFFF,
  parameter logic [CNT_W-1:0] L_MAX   = 21'h1ADB0,
  parameter logic [CNT_W-1:0] R_MIN   = 21'h2DC6C
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic [2:0]       pos,
  output logic             lost
);

  logic level, rise, fall;

  // Reset value 1 keeps the FSM in WAIT_LOW until a genuine low is seen on the pin.
  sync_edge #(.RST_VAL(1'b1)) u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt, per_cnt, per_nxt, hold_w, hold_nxt;
  logic [CNT_W-1:0] width_nxt, period_nxt, hi_inc, per_inc;
  logic [2:0]       pos_nxt;
  logic             valid_nxt, lost_nxt;

  function automatic logic [2:0] decode(input logic [CNT_W-1:0] w);
    if (w <= L_MAX)      return POS_L;
    else if (w >= R_MIN) return POS_R;
    else                 return POS_N;
  endfunction

  assign hi_inc  = (hi_cnt  == '1) ? hi_cnt  : hi_cnt  + 1'b1;
  assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= WAIT_LOW;
      hi_cnt  <= '0;
      per_cnt <= '0;
      hold_w  <= '0;
      width   <= '0;
      period  <= '0;
      valid   <= 1'b0;
      pos     <= POS_NONE;
      lost    <= 1'b1;
    end else begin
      state   <= state_nxt;
      hi_cnt  <= hi_nxt;
      per_cnt <= per_nxt;
      hold_w  <= hold_nxt;
      width   <= width_nxt;
      period  <= period_nxt;
      valid   <= valid_nxt;
      pos     <= pos_nxt;
      lost    <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hi_nxt     = hi_cnt;
    per_nxt    = per_cnt;
    hold_nxt   = hold_w;
    width_nxt  = width;
    period_nxt = period;
    valid_nxt  = 1'b0;
    pos_nxt    = pos;
    lost_nxt   = lost;
    case (state)
      WAIT_LOW: begin
        if (!level) begin
          state_nxt = WAIT_RISE;
          per_nxt   = '0;
        end
      end
      WAIT_RISE: begin
        per_nxt = per_inc;
        if (rise) begin
          state_nxt = HIGH;
          hi_nxt    = 1;
          per_nxt   = 1;
        end else if (per_cnt == TIMEOUT) begin
          lost_nxt = 1'b1;
          pos_nxt  = POS_NONE;
          per_nxt  = '0;
        end
      end
      HIGH: begin
        hi_nxt  = hi_inc;
        per_nxt = per_inc;
        // Timeout is checked first so a fall landing on TIMEOUT is still a loss.
        if (per_cnt == TIMEOUT) begin
          lost_nxt  = 1'b1;
          pos_nxt   = POS_NONE;
          state_nxt = WAIT_LOW;
        end else if (fall) begin
          hold_nxt  = hi_cnt;
          state_nxt = LOW;
        end
      end
      LOW: begin
        per_nxt = per_inc;
        // A rise on the TIMEOUT cycle still closes a good period.
        if (rise) begin
          width_nxt  = hold_w;
          period_nxt = per_cnt;
          pos_nxt    = decode(hold_w);
          valid_nxt  = 1'b1;
          lost_nxt   = 1'b0;
          hi_nxt     = 1;
          per_nxt    = 1;
          state_nxt  = HIGH;
        end else if (per_cnt == TIMEOUT) begin
          lost_nxt  = 1'b1;
          pos_nxt   = POS_NONE;
          per_nxt   = '0;
          state_nxt = WAIT_RISE;
        end
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed PWM waveforms checked against a rise/fall timestamp model.
module tb_pwm_capture;

  localparam int CW = 12;
  localparam int TO = 1000;
  localparam int LM = 110;
  localparam int RM = 187;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] width, period;
  logic          valid, lost;
  logic [2:0]    pos;

  pwm_capture #(
    .CNT_W  (CW),
    .TIMEOUT(12'd1000),
    .L_MAX  (12'd110),
    .R_MIN  (12'd187)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .pwm_in(pwm_in),
    .width (width),
    .period(period),
    .valid (valid),
    .pos   (pos),
    .lost  (lost)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: each pin rise closes the period opened by the previous rise, if one exists
  // since reset, when high time < TO and period <= TO. Report appears 3 edges later.
  typedef struct {
    int at;
    int w;
    int p;
    int ps;
  } exp_t;

  exp_t q[$];
  bit   armed = 0;
  int   rise_k = 0;
  int   fall_k = 0;

  function automatic int pos_of(input int w);
    if (w <= LM) return 4;
    if (w >= RM) return 1;
    return 2;
  endfunction

  // Called at a negedge: the new level is sampled at the next posedge.
  task automatic seg(input logic lvl, input int n);
    int k;
    k = cyc + 1;
    if (lvl != pwm_in) begin
      if (lvl) begin
        if (armed && (fall_k - rise_k) < TO && (k - rise_k) <= TO)
          q.push_back('{at: k + 3, w: fall_k - rise_k, p: k - rise_k, ps: pos_of(fall_k - rise_k)});
        armed  = 1;
        rise_k = k;
      end else begin
        fall_k = k;
      end
    end
    pwm_in = lvl;
    repeat (n) @(negedge CLK);
  endtask

  task automatic frame(input int h, input int p);
    seg(1'b1, h);
    seg(1'b0, p - h);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_width"}, width, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_pos"}, pos, 0);
    check({tag, "_lost"}, lost, 1);
    check({tag, "_valid"}, valid, 0);
  endtask

  // Every strobe must match the next expected report, on the exact cycle.
  always @(negedge CLK) begin
    if (valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("valid_cycle", cyc, e.at);
        check("width", width, e.w);
        check("period", period, e.p);
        check("pos", pos, e.ps);
        check("lost_on_valid", lost, 0);
      end
    end else if (q.size() > 0 && cyc > q[0].at) begin
      check("missed_valid", 0, 1);
      void'(q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset held while the pin toggles.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      pwm_in = ~pwm_in;
      repeat ($urandom_range(1, 5)) @(negedge CLK);
    end
    check_reset_outputs("rst_held");
    pwm_in = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    seg(1'b0, 10);

    // Neutral frames, then left/right and decode thresholds.
    repeat (3) frame(150, 600);
    frame(90, 600);
    frame(210, 600);
    frame(110, 500);
    frame(111, 500);
    frame(186, 500);
    frame(187, 500);
    frame(997, TO);
    frame(150, 600);

    // Stuck low after a good frame: loss exactly TO edges after the last rise is acted on.
    seg(1'b1, 150);
    seg(1'b0, 1);
    t = rise_k + 3 + TO;
    wait_until(t - 1);
    check("lost_low_early", lost, 0);
    wait_until(t);
    check("lost_low", lost, 1);
    check("pos_low_loss", pos, 0);
    check("width_hold_low", width, 150);
    check("period_hold_low", period, 600);
    repeat (1500) @(negedge CLK);
    check("still_lost", lost, 1);
    frame(150, 600);
    frame(150, 600);
    check("lost_cleared", lost, 0);

    // High for exactly TO cycles: fall and timeout coincide, timeout wins.
    seg(1'b1, 1);
    wait_until(rise_k + TO - 1);
    seg(1'b0, 1);
    t = rise_k + 3 + TO;
    wait_until(t - 1);
    check("lost_high_early", lost, 0);
    wait_until(t);
    check("lost_high", lost, 1);
    check("pos_high_loss", pos, 0);
    check("width_hold_high", width, 150);
    seg(1'b0, 300);
    frame(210, 600);
    frame(90, 600);

    // Held high from reset past TO, then released.
    RST = 1'b1;
    q.delete();
    armed  = 0;
    pwm_in = 1'b1;
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    repeat (TO + 200) @(negedge CLK);
    check("stuck_high_lost", lost, 1);
    check("stuck_high_pos", pos, 0);
    seg(1'b0, 300);
    frame(150, 600);
    frame(150, 600);

    // Reset mid high phase: asynchronous clear, truncated pulse not reported.
    seg(1'b1, 50);
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    q.delete();
    armed = 0;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    seg(1'b0, 400);
    frame(150, 600);
    frame(150, 600);

    // Random frames within the timeout.
    for (int i = 0; i < 30; i++)
      frame($urandom_range(3, 400), 0 + 0 + $urandom_range(3, 500) + 400);

    seg(1'b1, 10);
    seg(1'b0, 20);
    check("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
